// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: data/register widths, write-back source select,
// load-hold FSM states and the MEM/WB latch layout.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_MEM = 2'd1,
    SEL_NPC = 2'd2,
    SEL_RSV = 2'd3
  } regsel_t;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } holdstate_t;

  typedef struct packed {
    logic     valid;
    logic     regWr;
    regsel_t  regSel;
    regbits_t regDst;
    word_t    alu_out;
    word_t    load;
    word_t    npc;
  } wb_latch_t;

  localparam wb_latch_t WB_BUBBLE = '0;

  // Reserved select code falls back to the ALU result.
  function automatic word_t wb_mux(input regsel_t sel, input word_t alu,
                                   input word_t ld, input word_t npc);
    case (sel)
      SEL_MEM: wb_mux = ld;
      SEL_NPC: wb_mux = npc;
      default: wb_mux = alu;
    endcase
  endfunction
endpackage

// File: rtl/writeback_stage_load_hold_buf.sv
// One-entry buffer that keeps a load result which completed while the
// pipeline was stalled on ihit, plus the stage advance qualifier.
module load_hold_buf
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  flush,
  input  logic  dmemREN,
  input  word_t dmemload_next,
  output logic  held,
  output logic  advance,
  output word_t ld_data
);

  holdstate_t state, state_nx;
  word_t      hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hold_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == HELD) hold_q <= dmemload_next;
    end
  end

  // A second dhit while HELD is ignored so the captured word is never lost.
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (dmemREN && dhit && !ihit) state_nx = HELD;
        HELD:    if (advance) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    held    = (state == HELD);
    advance = ihit & (~dmemREN | dhit | held);
    ld_data = held ? hold_q : dmemload_next;
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB latch and register-file write-back mux, with load-hold buffer,
// sticky halt and retired-instruction counter.
module writeback_stage
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             flush,
  input  logic             dmemREN,
  input  word_t            nPC_next,
  input  logic             regWr_next,
  input  regsel_t          regSel_next,
  input  regbits_t         regDst_next,
  input  word_t            ALUOut_next,
  input  word_t            dmemload_next,
  input  logic             halt_next,
  output logic             WEN,
  output regbits_t         wsel,
  output word_t            wdat,
  output logic             fwd_valid,
  output regbits_t         fwd_reg,
  output word_t            fwd_data,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count
);

  logic      held, advance;
  word_t     ld_data;
  wb_latch_t lat;
  logic      wb_pend;
  logic      halt_q;
  logic [CNT_W-1:0] cnt;

  load_hold_buf u_hold (
    .clk           (CLK),
    .rst           (RST),
    .ihit          (ihit),
    .dhit          (dhit),
    .flush         (flush),
    .dmemREN       (dmemREN),
    .dmemload_next (dmemload_next),
    .held          (held),
    .advance       (advance),
    .ld_data       (ld_data)
  );

  // flush beats advance: a bubble is captured and nothing retires.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lat     <= WB_BUBBLE;
      wb_pend <= 1'b0;
      halt_q  <= 1'b0;
      cnt     <= '0;
    end else if (flush) begin
      lat     <= WB_BUBBLE;
      wb_pend <= 1'b0;
    end else if (advance) begin
      lat.valid   <= 1'b1;
      lat.regWr   <= regWr_next;
      lat.regSel  <= regSel_next;
      lat.regDst  <= regDst_next;
      lat.alu_out <= ALUOut_next;
      lat.load    <= ld_data;
      lat.npc     <= nPC_next;
      wb_pend     <= 1'b1;
      if (halt_next) halt_q <= 1'b1;
      if (!halt_q)   cnt    <= cnt + CNT_W'(1);
    end else begin
      wb_pend <= 1'b0;
    end
  end

  always_comb begin
    wsel        = lat.regDst;
    wdat        = wb_mux(lat.regSel, lat.alu_out, lat.load, lat.npc);
    fwd_valid   = lat.valid & lat.regWr & (lat.regDst != '0);
    WEN         = wb_pend & fwd_valid;
    fwd_reg     = wsel;
    fwd_data    = wdat;
    halt        = halt_q;
    instr_count = cnt;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;
  import cpu_types_pkg::*;

  logic     CLK = 1'b0;
  logic     RST, ihit, dhit, flush, dmemREN, regWr_next, halt_next;
  word_t    nPC_next, ALUOut_next, dmemload_next;
  regsel_t  regSel_next;
  regbits_t regDst_next;
  logic     WEN, fwd_valid, halt;
  regbits_t wsel, fwd_reg;
  word_t    wdat, fwd_data;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  writeback_stage #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .dmemREN(dmemREN), .nPC_next(nPC_next), .regWr_next(regWr_next),
    .regSel_next(regSel_next), .regDst_next(regDst_next),
    .ALUOut_next(ALUOut_next), .dmemload_next(dmemload_next),
    .halt_next(halt_next), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .halt(halt), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    ihit = 0; dhit = 0; flush = 0; dmemREN = 0; regWr_next = 0; halt_next = 0;
    nPC_next = '0; ALUOut_next = '0; dmemload_next = '0;
    regSel_next = SEL_ALU; regDst_next = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".WEN"}, WEN, 0);
    chk({tag, ".wsel"}, wsel, 0);
    chk({tag, ".wdat"}, wdat, 0);
    chk({tag, ".fwd_valid"}, fwd_valid, 0);
    chk({tag, ".fwd_reg"}, fwd_reg, 0);
    chk({tag, ".fwd_data"}, fwd_data, 0);
    chk({tag, ".halt"}, halt, 0);
    chk({tag, ".cnt"}, instr_count, 0);
    chk({tag, ".held"}, dut.held, 0);
  endtask

  initial begin
    idle_in();
    RST = 1;
    tick(); tick();
    RST = 0;
    chk_all_zero("rst");

    // ALU write, then stall: WEN lasts one cycle, forwarding persists
    ihit = 1; regWr_next = 1; regDst_next = 8; regSel_next = SEL_ALU; ALUOut_next = 32'h1234;
    tick();
    chk("alu.WEN", WEN, 1);
    chk("alu.wsel", wsel, 8);
    chk("alu.wdat", wdat, 32'h1234);
    chk("alu.fwd_data", fwd_data, 32'h1234);
    chk("alu.cnt", instr_count, 1);
    ihit = 0;
    tick();
    chk("alu.WEN_off", WEN, 0);
    chk("alu.fwd_hold", fwd_valid, 1);
    chk("alu.fwd_reg", fwd_reg, 8);

    // load arrives while stalled; second dhit must not overwrite the hold
    dmemREN = 1; dhit = 1; dmemload_next = 32'hCAFEBABE; regDst_next = 9; regSel_next = SEL_MEM;
    tick();
    chk("ld.held0", dut.held, 1);
    chk("ld.WEN0", WEN, 0);
    dmemload_next = 32'hDEADBEEF;
    tick();
    chk("ld.held1", dut.held, 1);
    ihit = 1; dhit = 0; dmemload_next = '0;
    tick();
    chk("ld.WEN", WEN, 1);
    chk("ld.wsel", wsel, 9);
    chk("ld.wdat", wdat, 32'hCAFEBABE);
    chk("ld.idle", dut.held, 0);
    chk("ld.cnt", instr_count, 2);

    // dhit and ihit together: direct data, no hold
    dhit = 1; dmemload_next = 32'h11112222; regDst_next = 10;
    tick();
    chk("ldd.wdat", wdat, 32'h11112222);
    chk("ldd.WEN", WEN, 1);
    chk("ldd.held", dut.held, 0);
    chk("ldd.cnt", instr_count, 3);

    // load still waiting on dhit: no advance
    dhit = 0;
    tick();
    chk("stall.WEN", WEN, 0);
    chk("stall.cnt", instr_count, 3);

    // $0 write suppressed but retired
    dmemREN = 0; regDst_next = 0; regSel_next = SEL_ALU; ALUOut_next = 32'h55;
    tick();
    chk("r0.WEN", WEN, 0);
    chk("r0.fwd", fwd_valid, 0);
    chk("r0.cnt", instr_count, 4);

    // flush beats advance
    flush = 1; regDst_next = 12; ALUOut_next = 32'h77;
    tick();
    chk("fl.WEN", WEN, 0);
    chk("fl.fwd", fwd_valid, 0);
    chk("fl.cnt", instr_count, 4);

    // flush while HELD
    flush = 0; ihit = 0; dmemREN = 1; dhit = 1; dmemload_next = 32'hAAAA;
    tick();
    chk("flh.held", dut.held, 1);
    flush = 1; dhit = 0;
    tick();
    chk("flh.idle", dut.held, 0);
    chk("flh.cnt", instr_count, 4);
    flush = 0; dmemREN = 0;

    // jal writes PC+4
    ihit = 1; regWr_next = 1; regDst_next = 31; regSel_next = SEL_NPC;
    nPC_next = 32'h40; ALUOut_next = 32'h999;
    tick();
    chk("jal.WEN", WEN, 1);
    chk("jal.wsel", wsel, 31);
    chk("jal.wdat", wdat, 32'h40);
    chk("jal.cnt", instr_count, 5);

    // halt is sticky; counter freezes while latch keeps updating
    halt_next = 1; regWr_next = 0;
    tick();
    chk("halt.set", halt, 1);
    chk("halt.cnt", instr_count, 6);
    chk("halt.WEN", WEN, 0);
    halt_next = 0; regWr_next = 1; regDst_next = 5; regSel_next = SEL_ALU; ALUOut_next = 32'h321;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt.sticky", halt, 1);
      chk("halt.frozen", instr_count, 6);
    end
    chk("halt.latch", wdat, 32'h321);

    // reset while HELD with count at 5
    idle_in();
    RST = 1;
    tick();
    RST = 0;
    chk("rst2.halt", halt, 0);
    ihit = 1; regWr_next = 1; regDst_next = 3;
    for (int i = 0; i < 5; i++) begin
      ALUOut_next = 32'(i + 1);
      tick();
    end
    chk("pre.cnt", instr_count, 5);
    ihit = 0; dmemREN = 1; dhit = 1; dmemload_next = 32'hBEEF;
    tick();
    chk("pre.held", dut.held, 1);
    RST = 1;
    tick();
    chk_all_zero("rst3");
    RST = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=done");
    $fatal(1);
  end
endmodule
